// File: rtl/router_term_fifo_bank.sv
// Per-terminal injection/capture FIFO bank for the ROWSxCOLUMS mesh router edge terminals.
// Optional build macro ROUTER_TERM_STATS_EN adds per-channel inj_cnt/ej_cnt statistics.
module router_term_fifo_bank #(
    parameter int ROWS       = 4,
    parameter int COLUMS     = 4,
    parameter int PCKG_SZ    = 40,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16,
    localparam int NTERM     = 2*ROWS + 2*COLUMS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NTERM-1:0]         drv_push,
    input  logic [NTERM*PCKG_SZ-1:0] drv_data,
    output logic [NTERM-1:0]         drv_full,
    output logic [NTERM-1:0]         pndng,
    output logic [NTERM*PCKG_SZ-1:0] data_out,
    input  logic [NTERM-1:0]         pop,
    input  logic [NTERM-1:0]         pndng_i_in,
    input  logic [NTERM*PCKG_SZ-1:0] data_out_i_in,
    output logic [NTERM-1:0]         popin,
    output logic [NTERM-1:0]         mon_vld,
    output logic [NTERM*PCKG_SZ-1:0] mon_data,
    input  logic [NTERM-1:0]         mon_rd,
    output logic [NTERM*CNT_W-1:0]   drop_cnt,
    output logic [NTERM-1:0]         ovf
`ifdef ROUTER_TERM_STATS_EN
    ,
    output logic [NTERM*CNT_W-1:0]   inj_cnt,
    output logic [NTERM*CNT_W-1:0]   ej_cnt
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake: a transfer happens on a clock edge where the producer's request
    // (push/pop/popin/mon_rd) is high and the receiving side can take it; requests
    // against an empty source are ignored, pushes into a full injection FIFO drop.
    for (genvar i = 0; i < NTERM; i++) begin : g_ch
        logic [PCKG_SZ-1:0] inj_mem [FIFO_DEPTH];
        logic [PW-1:0]      inj_wr, inj_rd;
        logic [CW-1:0]      inj_count;
        logic               inj_full, inj_push, inj_pop, inj_drop;
        logic [CNT_W-1:0]   drop_q;
        logic               ovf_q;

        logic [PCKG_SZ-1:0] cap_mem [FIFO_DEPTH];
        logic [PW-1:0]      cap_wr, cap_rd;
        logic [CW-1:0]      cap_count;
        logic               cap_full, cap_push, cap_pop;

        assign inj_full = (inj_count == CW'(FIFO_DEPTH));
        assign inj_pop  = pop[i] & (inj_count != '0);
        // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
        assign inj_push = drv_push[i] & (~inj_full | inj_pop);
        assign inj_drop = drv_push[i] & inj_full & ~inj_pop;

        assign cap_full = (cap_count == CW'(FIFO_DEPTH));
        assign cap_push = pndng_i_in[i] & ~cap_full;
        assign cap_pop  = mon_rd[i] & (cap_count != '0);

        assign drv_full[i] = inj_full;
        assign pndng[i]    = (inj_count != '0);
        assign data_out[i*PCKG_SZ +: PCKG_SZ] = (inj_count != '0) ? inj_mem[inj_rd] : '0;
        assign popin[i]    = cap_push;
        assign mon_vld[i]  = (cap_count != '0);
        assign mon_data[i*PCKG_SZ +: PCKG_SZ] = (cap_count != '0) ? cap_mem[cap_rd] : '0;
        assign drop_cnt[i*CNT_W +: CNT_W] = drop_q;
        assign ovf[i]      = ovf_q;

        always_ff @(posedge clk) begin
            if (inj_push) inj_mem[inj_wr] <= drv_data[i*PCKG_SZ +: PCKG_SZ];
            if (cap_push) cap_mem[cap_wr] <= data_out_i_in[i*PCKG_SZ +: PCKG_SZ];
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                inj_wr    <= '0;
                inj_rd    <= '0;
                inj_count <= '0;
                cap_wr    <= '0;
                cap_rd    <= '0;
                cap_count <= '0;
                drop_q    <= '0;
                ovf_q     <= 1'b0;
            end else begin
                if (inj_push) inj_wr <= ptr_inc(inj_wr);
                if (inj_pop)  inj_rd <= ptr_inc(inj_rd);
                case ({inj_push, inj_pop})
                    2'b10:   inj_count <= inj_count + 1'b1;
                    2'b01:   inj_count <= inj_count - 1'b1;
                    default: inj_count <= inj_count;
                endcase
                if (cap_push) cap_wr <= ptr_inc(cap_wr);
                if (cap_pop)  cap_rd <= ptr_inc(cap_rd);
                case ({cap_push, cap_pop})
                    2'b10:   cap_count <= cap_count + 1'b1;
                    2'b01:   cap_count <= cap_count - 1'b1;
                    default: cap_count <= cap_count;
                endcase
                if (inj_drop) begin
                    ovf_q <= 1'b1;
                    if (drop_q != '1) drop_q <= drop_q + 1'b1;
                end
            end
        end

`ifdef ROUTER_TERM_STATS_EN
        logic [CNT_W-1:0] inj_q, ej_q;
        assign inj_cnt[i*CNT_W +: CNT_W] = inj_q;
        assign ej_cnt[i*CNT_W +: CNT_W]  = ej_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                inj_q <= '0;
                ej_q  <= '0;
            end else begin
                if (inj_pop && inj_q != '1)  inj_q <= inj_q + 1'b1;
                if (cap_push && ej_q != '1)  ej_q  <= ej_q + 1'b1;
            end
        end
`endif
    end

endmodule
